// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and constants for the two-master memory bus arbiter.
//   - arb_state_e : FSM state encoding (IDLE/BUSY/DONE; 3 is unreachable)
//   - owner_e     : one-hot bus owner, bit-identical to the grant output
//   - DEF_*       : default values of the arbiter parameters
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // One-hot so the registered owner can drive grant directly.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  localparam int DEF_MAX_WAIT = 8;
  localparam int DEF_TIMEOUT  = 255;

  // Width of the bus timeout counter.
  localparam int TMO_W = 8;

  // True when a one-hot owner value selects master 1.
  function automatic logic owner_is_m1(input owner_e own);
    return (own == OWN_M1);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Groups the two master request ports and the shared memory/MIO bus port.
//   m0_* / m1_*   : master request side (req, addr, wdata, we, ramctrl in;
//                   rdata, ready, err out)
//   mem_*         : shared bus side (req, addr, wdata, we, ramctrl out;
//                   rdata, ready in)
//
// Handshake: a master raises mX_req with addr/wdata/we/ramctrl stable and
// holds all of them until it sees mX_ready=1 for one cycle; mX_rdata and
// mX_err are valid only in that cycle. The master must drop mX_req by the
// clock edge that ends the ready cycle, otherwise a new access starts. On the
// bus, mem_req=1 presents an access that completes on the cycle mem_ready=1;
// mem_ready seen while mem_req=0 has no effect.
//
// Modports:
//   slave  : arbiter view (serves the masters, drives the bus)
//   master : environment view (masters plus memory model)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_we;
  logic [2:0]  m0_ramctrl;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic [2:0]  m1_ramctrl;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        m1_err;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_ramctrl;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we, m0_ramctrl,
    input  m1_req, m1_addr, m1_wdata, m1_we, m1_ramctrl,
    output m0_rdata, m0_ready, m0_err,
    output m1_rdata, m1_ready, m1_err,
    output mem_req, mem_addr, mem_wdata, mem_we, mem_ramctrl,
    input  mem_rdata, mem_ready
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we, m0_ramctrl,
    output m1_req, m1_addr, m1_wdata, m1_we, m1_ramctrl,
    input  m0_rdata, m0_ready, m0_err,
    input  m1_rdata, m1_ready, m1_err,
    input  mem_req, mem_addr, mem_wdata, mem_we, mem_ramctrl,
    output mem_rdata, mem_ready
  );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_bus_arbiter_arb_picker.sv
// ---------------------------------------------------------------------------
// arb_picker
//
// Combinational winner select for the arbiter's IDLE state.
//   m0_req_i  in  1  master 0 (CPU) request
//   m1_req_i  in  1  master 1 (DMA/peripheral) request
//   starve_i  in  1  master 1 has waited MAX_WAIT cycles
//   grant_o   out 2  one-hot winner (owner_e encoding), 00 when no request
//
// Master 0 has fixed priority; master 1 wins when it is the only requester
// or when the starvation guard fires.
// ---------------------------------------------------------------------------
module arb_picker
  import mem_arb_pkg::*;
(
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       starve_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = OWN_NONE;
    if (m1_req_i && (starve_i || !m0_req_i)) begin
      grant_o = OWN_M1;
    end else if (m0_req_i) begin
      grant_o = OWN_M0;
    end
  end

endmodule : arb_picker

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory/MIO port between the CPU (master 0) and a DMA/peripheral
// master (master 1). One access at a time: IDLE picks an owner, BUSY presents
// the owner's request on the bus until mem_ready or timeout, DONE returns a
// one-cycle ready pulse with read data and error flag to the owner.
//
// Parameters:
//   MAX_WAIT  cycles master 1 may wait before overriding CPU priority (1..15)
//   TIMEOUT   BUSY cycles without mem_ready before abort (1..255)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    if   mem_bus_arbiter_if.slave (master request ports + memory bus)
//   grant  out  one-hot current owner, 00 in IDLE
//   state  out  FSM state for debug (arb_state_e encoding)
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
)
(
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus,
  output logic [1:0]          grant,
  output logic [1:0]          state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  // Last BUSY cycle index before the access is declared timed out; the
  // counter starts at 0 in the first BUSY cycle.
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [1:0]         pick_grant;
  logic               starve;
  logic               any_req;
  logic               tmo_hit;
  logic               m1_granting;

  assign any_req = bus.m0_req || bus.m1_req;
  assign starve  = (wait_cnt_q == WAIT_MAX);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  arb_picker u_picker (
    .m0_req_i (bus.m0_req),
    .m1_req_i (bus.m1_req),
    .starve_i (starve),
    .grant_o  (pick_grant)
  );

  // Master 1 is being handed the bus on this edge.
  assign m1_granting = (state_q == ST_IDLE) && (pick_grant == OWN_M1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tmo_cnt_d = tmo_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (any_req) begin
          state_d   = ST_BUSY;
          owner_d   = owner_e'(pick_grant);
          tmo_cnt_d = '0;
        end
      end

      ST_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // mem_ready takes precedence over a timeout in the same cycle.
        if (bus.mem_ready) begin
          state_d = ST_DONE;
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        // Encoding 3 cannot be reached; fall back to a clean IDLE.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Starvation counter: counts cycles master 1 waits behind another owner.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.m1_req || owner_is_m1(owner_q) || m1_granting) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: bus mux in BUSY, completion return in DONE, zeros elsewhere.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_addr    = 32'h0;
    bus.mem_wdata   = 32'h0;
    bus.mem_we      = 1'b0;
    bus.mem_ramctrl = 3'b000;
    bus.m0_ready    = 1'b0;
    bus.m0_rdata    = 32'h0;
    bus.m0_err      = 1'b0;
    bus.m1_ready    = 1'b0;
    bus.m1_rdata    = 32'h0;
    bus.m1_err      = 1'b0;
    grant           = owner_q;
    state           = state_q;

    case (state_q)
      ST_BUSY: begin
        bus.mem_req = 1'b1;
        // Owner inputs are steered live; masters hold them stable while req.
        if (owner_is_m1(owner_q)) begin
          bus.mem_addr    = bus.m1_addr;
          bus.mem_wdata   = bus.m1_wdata;
          bus.mem_we      = bus.m1_we;
          bus.mem_ramctrl = bus.m1_ramctrl;
        end else begin
          bus.mem_addr    = bus.m0_addr;
          bus.mem_wdata   = bus.m0_wdata;
          bus.mem_we      = bus.m0_we;
          bus.mem_ramctrl = bus.m0_ramctrl;
        end
      end

      ST_DONE: begin
        if (owner_q == OWN_M0) begin
          bus.m0_ready = 1'b1;
          bus.m0_rdata = rdata_q;
          bus.m0_err   = err_q;
        end else if (owner_q == OWN_M1) begin
          bus.m1_ready = 1'b1;
          bus.m1_rdata = rdata_q;
          bus.m1_err   = err_q;
        end
      end

      default: ;
    endcase
  end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_a ();
  mem_bus_arbiter_if bus_b ();
  logic [1:0] grant_a, state_a, grant_b, state_b;

  mem_bus_arbiter #(.MAX_WAIT(8), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .grant(grant_a), .state(state_a)
  );

  mem_bus_arbiter #(.MAX_WAIT(8), .TIMEOUT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .grant(grant_b), .state(state_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  e_state;
    logic [1:0]  e_grant;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [2:0]  e_ramctrl;
    logic [1:0]  e_ready;   // {m1_ready, m0_ready}
    logic [31:0] e_rdata;   // rdata of the master whose ready is set
    logic [1:0]  e_err;     // {m1_err, m0_err}
    string       tag;
  } vec_t;

  localparam logic       Y = 1'b1;
  localparam logic       N = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam logic [1:0] SI = 2'd0, SB = 2'd1, SD = 2'd2;
  localparam logic [1:0] G0 = 2'b00, GA = 2'b01, GB = 2'b10;
  localparam logic [2:0] RC0 = 3'b001, RC1 = 3'b110, RCN = 3'b000;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic m0r, input logic m0we, input logic [31:0] m0a, input logic [31:0] m0wd,
    input logic m1r, input logic m1we, input logic [31:0] m1a, input logic [31:0] m1wd,
    input logic rdy, input logic [31:0] rdat,
    input logic [1:0] st, input logic [1:0] gr, input logic mreq, input logic mwe,
    input logic [31:0] maddr, input logic [31:0] mwd, input logic [2:0] mrc,
    input logic [1:0] erdy, input logic [31:0] erdat, input logic [1:0] eerr, input string tag);
    vec_t v;
    v.m0_req = m0r; v.m0_we = m0we; v.m0_addr = m0a; v.m0_wdata = m0wd;
    v.m1_req = m1r; v.m1_we = m1we; v.m1_addr = m1a; v.m1_wdata = m1wd;
    v.mem_ready = rdy; v.mem_rdata = rdat;
    v.e_state = st; v.e_grant = gr; v.e_mem_req = mreq; v.e_mem_we = mwe;
    v.e_mem_addr = maddr; v.e_mem_wdata = mwd; v.e_ramctrl = mrc;
    v.e_ready = erdy; v.e_rdata = erdat; v.e_err = eerr; v.tag = tag;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_a(input vec_t v);
    bus_a.m0_req   = v.m0_req;   bus_a.m0_we   = v.m0_we;
    bus_a.m0_addr  = v.m0_addr;  bus_a.m0_wdata = v.m0_wdata;
    bus_a.m1_req   = v.m1_req;   bus_a.m1_we   = v.m1_we;
    bus_a.m1_addr  = v.m1_addr;  bus_a.m1_wdata = v.m1_wdata;
    bus_a.mem_ready = v.mem_ready; bus_a.mem_rdata = v.mem_rdata;
  endtask

  task automatic check_a(input vec_t v);
    chk({v.tag, " state"},     32'(state_a),           32'(v.e_state));
    chk({v.tag, " grant"},     32'(grant_a),           32'(v.e_grant));
    chk({v.tag, " mem_req"},   32'(bus_a.mem_req),     32'(v.e_mem_req));
    chk({v.tag, " mem_we"},    32'(bus_a.mem_we),      32'(v.e_mem_we));
    chk({v.tag, " mem_addr"},  bus_a.mem_addr,         v.e_mem_addr);
    chk({v.tag, " mem_wdata"}, bus_a.mem_wdata,        v.e_mem_wdata);
    chk({v.tag, " mem_ramctrl"}, 32'(bus_a.mem_ramctrl), 32'(v.e_ramctrl));
    chk({v.tag, " ready"},     32'({bus_a.m1_ready, bus_a.m0_ready}), 32'(v.e_ready));
    chk({v.tag, " err"},       32'({bus_a.m1_err, bus_a.m0_err}),     32'(v.e_err));
    chk({v.tag, " m0_rdata"},  bus_a.m0_rdata, v.e_ready[0] ? v.e_rdata : Z);
    chk({v.tag, " m1_rdata"},  bus_a.m1_rdata, v.e_ready[1] ? v.e_rdata : Z);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic seen;

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    bus_a.m0_ramctrl = RC0; bus_a.m1_ramctrl = RC1;
    bus_b.m0_ramctrl = RC0; bus_b.m1_ramctrl = RC1;
    drive_a(mk(N,N,Z,Z, N,N,Z,Z, N,Z, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "init"));
    bus_b.m0_req = N; bus_b.m0_we = N; bus_b.m0_addr = Z; bus_b.m0_wdata = Z;
    bus_b.m1_req = N; bus_b.m1_we = N; bus_b.m1_addr = Z; bus_b.m1_wdata = Z;
    bus_b.mem_ready = N; bus_b.mem_rdata = Z;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst state_a", 32'(state_a), 32'h0);
    chk("rst grant_a", 32'(grant_a), 32'h0);
    chk("rst mem_req_a", 32'(bus_a.mem_req), 32'h0);
    chk("rst mem_we_a", 32'(bus_a.mem_we), 32'h0);
    chk("rst ready_a", 32'({bus_a.m1_ready, bus_a.m0_ready}), 32'h0);
    chk("rst err_a", 32'({bus_a.m1_err, bus_a.m0_err}), 32'h0);
    chk("rst state_b", 32'(state_b), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // CPU read alone
    vq.push_back(mk(Y,N,32'h100,Z, N,N,Z,Z, N,Z,            SB,GA,Y,N,32'h100,Z,RC0, 2'b00,Z,2'b00, "rd_busy"));
    vq.push_back(mk(Y,N,32'h100,Z, N,N,Z,Z, Y,32'hCAFEF00D, SD,GA,N,N,Z,Z,RCN, 2'b01,32'hCAFEF00D,2'b00, "rd_done"));
    vq.push_back(mk(N,N,Z,Z,       N,N,Z,Z, N,Z,            SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "rd_idle"));
    // Master 1 write alone, two BUSY cycles
    vq.push_back(mk(N,N,Z,Z, Y,Y,32'h2000,32'h12345678, N,Z, SB,GB,Y,Y,32'h2000,32'h12345678,RC1, 2'b00,Z,2'b00, "wr_busy1"));
    vq.push_back(mk(N,N,Z,Z, Y,Y,32'h2000,32'h12345678, N,Z, SB,GB,Y,Y,32'h2000,32'h12345678,RC1, 2'b00,Z,2'b00, "wr_busy2"));
    vq.push_back(mk(N,N,Z,Z, Y,Y,32'h2000,32'h12345678, Y,Z, SD,GB,N,N,Z,Z,RCN, 2'b10,Z,2'b00, "wr_done"));
    vq.push_back(mk(N,N,Z,Z, N,N,Z,Z, N,Z, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "wr_idle"));
    // Stray mem_ready in IDLE is ignored
    vq.push_back(mk(N,N,Z,Z, N,N,Z,Z, Y,32'hFFFFFFFF, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "stray_rdy"));
    // Timeout, TIMEOUT=4: four BUSY cycles then DONE with err
    vq.push_back(mk(Y,N,32'h300,Z, N,N,Z,Z, N,32'hBAD0BAD0, SB,GA,Y,N,32'h300,Z,RC0, 2'b00,Z,2'b00, "tmo_b1"));
    vq.push_back(mk(Y,N,32'h300,Z, N,N,Z,Z, N,32'hBAD0BAD0, SB,GA,Y,N,32'h300,Z,RC0, 2'b00,Z,2'b00, "tmo_b2"));
    vq.push_back(mk(Y,N,32'h300,Z, N,N,Z,Z, N,32'hBAD0BAD0, SB,GA,Y,N,32'h300,Z,RC0, 2'b00,Z,2'b00, "tmo_b3"));
    vq.push_back(mk(Y,N,32'h300,Z, N,N,Z,Z, N,32'hBAD0BAD0, SB,GA,Y,N,32'h300,Z,RC0, 2'b00,Z,2'b00, "tmo_b4"));
    vq.push_back(mk(Y,N,32'h300,Z, N,N,Z,Z, N,32'hBAD0BAD0, SD,GA,N,N,Z,Z,RCN, 2'b01,Z,2'b01, "tmo_done"));
    vq.push_back(mk(N,N,Z,Z, N,N,Z,Z, N,Z, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "tmo_idle"));
    // Both masters request continuously; mem_ready always 1.
    // Waits seen in IDLE: 0,3,6 -> CPU; 8 -> master 1; then cleared -> CPU.
    for (int k = 0; k < 3; k++) begin
      vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SB,GA,Y,N,32'h400,Z,RC0, 2'b00,Z,2'b00, $sformatf("st_m0busy%0d", k)));
      vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SD,GA,N,N,Z,Z,RCN, 2'b01,32'h11110000,2'b00, $sformatf("st_m0done%0d", k)));
      vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, $sformatf("st_idle%0d", k)));
    end
    vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SB,GB,Y,N,32'h500,32'hAAAA5555,RC1, 2'b00,Z,2'b00, "st_m1busy"));
    vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SD,GB,N,N,Z,Z,RCN, 2'b10,32'h11110000,2'b00, "st_m1done"));
    vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "st_idle3"));
    vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SB,GA,Y,N,32'h400,Z,RC0, 2'b00,Z,2'b00, "st_m0again"));
    vq.push_back(mk(Y,N,32'h400,Z, Y,N,32'h500,32'hAAAA5555, Y,32'h11110000, SD,GA,N,N,Z,Z,RCN, 2'b01,32'h11110000,2'b00, "st_m0again_done"));
    vq.push_back(mk(N,N,Z,Z, N,N,Z,Z, N,Z, SI,G0,N,N,Z,Z,RCN, 2'b00,Z,2'b00, "st_end"));

    for (int i = 0; i < vq.size(); i++) begin
      drive_a(vq[i]);
      cycle();
      check_a(vq[i]);
    end

    // Reset asserted mid-BUSY on a write
    bus_a.m0_req = Y; bus_a.m0_we = Y; bus_a.m0_addr = 32'h600; bus_a.m0_wdata = 32'h5A5A5A5A;
    bus_a.mem_ready = N; bus_a.mem_rdata = Z;
    cycle();
    chk("rstmid busy state", 32'(state_a), 32'(SB));
    chk("rstmid busy we", 32'(bus_a.mem_we), 32'h1);
    #2 reset = 1'b0;
    bus_a.mem_ready = Y; bus_a.mem_rdata = 32'h99999999;
    #1;
    chk("rstmid state", 32'(state_a), 32'h0);
    chk("rstmid grant", 32'(grant_a), 32'h0);
    chk("rstmid mem_req", 32'(bus_a.mem_req), 32'h0);
    chk("rstmid mem_we", 32'(bus_a.mem_we), 32'h0);
    chk("rstmid mem_addr", bus_a.mem_addr, Z);
    chk("rstmid mem_wdata", bus_a.mem_wdata, Z);
    cycle();
    chk("rstmid no ready", 32'({bus_a.m1_ready, bus_a.m0_ready}), 32'h0);
    bus_a.m0_req = N; bus_a.m0_we = N; bus_a.mem_ready = N;
    reset = 1'b1;
    cycle();
    chk("rstmid after state", 32'(state_a), 32'(SI));
    chk("rstmid after ready", 32'({bus_a.m1_ready, bus_a.m0_ready}), 32'h0);
    // Re-request completes normally
    bus_a.m0_req = Y; bus_a.m0_we = N; bus_a.m0_addr = 32'h700;
    bus_a.mem_ready = Y; bus_a.mem_rdata = 32'h0BADCAFE;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (bus_a.m0_ready) begin
        seen = 1'b1;
        chk("rereq rdata", bus_a.m0_rdata, 32'h0BADCAFE);
        chk("rereq err", 32'(bus_a.m0_err), 32'h0);
        bus_a.m0_req = N; bus_a.mem_ready = N;
      end
    end
    chk("rereq completed", 32'(seen), 32'h1);
    bus_a.m0_req = N; bus_a.mem_ready = N;
    cycle();
    chk("rereq idle", 32'(state_a), 32'(SI));

    // mem_ready and timeout coincide on dut_b (TIMEOUT=3)
    bus_b.m0_req = Y; bus_b.m0_we = N; bus_b.m0_addr = 32'h800;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk($sformatf("coin busy%0d state", c + 1), 32'(state_b), 32'(SB));
      chk($sformatf("coin busy%0d grant", c + 1), 32'(grant_b), 32'(GA));
    end
    bus_b.mem_ready = Y; bus_b.mem_rdata = 32'h77778888;
    cycle();
    chk("coin state", 32'(state_b), 32'(SD));
    chk("coin ready", 32'(bus_b.m0_ready), 32'h1);
    chk("coin err", 32'(bus_b.m0_err), 32'h0);
    chk("coin rdata", bus_b.m0_rdata, 32'h77778888);
    bus_b.m0_req = N; bus_b.mem_ready = N;
    cycle();
    chk("coin idle", 32'(state_b), 32'(SI));
    chk("coin idle ready", 32'(bus_b.m0_ready), 32'h0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single external memory/MMIO port between the multi-cycle CPU (master 0) and a DMA/peripheral master (master 1). Sits between the CPU top level and the memory/MIO bus. It serialises accesses, steers address/data/control to the bus, and returns read data and a one-cycle completion pulse to the owning master. It also provides fixed CPU priority with a starvation guard and a bus timeout.

## Interface
- MAX_WAIT, 8: cycles master 1 may wait with req high before it overrides CPU priority (1..15)
- TIMEOUT, 255: BUSY cycles without mem_ready before the access is aborted (1..255)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces every register to its reset value
- m0_req / m1_req  in  1  access request; held high until that master's ready pulse
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_ramctrl / m1_ramctrl  in  3  access size/sign code, passed through unchanged
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is 1
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  qualifies ready: 1 = access timed out
- mem_req  out  1  bus access strobe
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_we  out  1  bus write enable
- mem_ramctrl  out  3  bus size/sign code
- mem_rdata  in  32  bus read data
- mem_ready  in  1  bus completion (MIO_ready semantics)
- grant  out  2  one-hot current owner, 00 when idle
- state  out  2  FSM state for debug

## Operation
- FSM states, encoded in the package: IDLE=0, BUSY=1, DONE=2. Encoding 3 is unreachable and recovers to IDLE.
- IDLE
  - If no request: stay in IDLE.
  - Otherwise pick an owner and go to BUSY.
  - Default winner is master 0.
  - Master 1 wins if only m1_req is high, or if wait_cnt == MAX_WAIT.
- BUSY
  - mem_req=1; mem_addr/wdata/we/ramctrl are muxed from the owner's inputs.
  - On mem_ready=1: latch mem_rdata into rdata_q, err_q=0, go to DONE.
  - If tmo_cnt reaches TIMEOUT first: rdata_q=32'h0, err_q=1, go to DONE.
- DONE
  - mem_req=0.
  - Owner's ready=1, owner's rdata=rdata_q, owner's err=err_q.
  - Always go to IDLE.
- Outside DONE, both ready=0 and both rdata=0.
- When mem_req=0, mem_we=0 and mem_addr/wdata/ramctrl=0. A write is never presented outside BUSY.
- wait_cnt
  - Increments each cycle m1_req=1 and master 1 is not the owner; saturates at MAX_WAIT.
  - Clears when master 1 is granted or m1_req=0.
  - Width: clog2(MAX_WAIT+1).
- tmo_cnt: 8-bit; cleared on entry to BUSY; increments each BUSY cycle.
- A request dropped mid-BUSY does not abort the access. Completion proceeds and the ready pulse is still issued.
- Owner inputs are muxed live, not captured. Masters must hold addr/wdata/we/ramctrl stable while req is high.

## Timing
- Reset values:
  - state=IDLE, grant=00, mem_req=0, mem_we=0.
  - All data outputs 0, both ready=0, both err=0.
  - wait_cnt=0, tmo_cnt=0.
- Reset asserted mid-access: immediate return to IDLE, no ready pulse. The interrupted master must re-request.
- Latency:
  - req sampled high in IDLE at edge 0.
  - BUSY from cycle 1.
  - mem_ready seen at edge k (k≥2).
  - DONE (ready pulse) in cycle k.
  - IDLE in cycle k+1.
  - Minimum 3 cycles per access when mem_ready returns in the first BUSY cycle.
- Masters must deassert req by the edge ending their DONE cycle; a registered clear on sampling ready meets this. A req still high in the following IDLE is treated as a new access.
- Simultaneous m0_req and m1_req in IDLE, with wait_cnt < MAX_WAIT: master 0 wins, and wait_cnt keeps counting.
- mem_ready and timeout in the same cycle: mem_ready wins, err=0.
- mem_ready outside BUSY: ignored.

## Structure
- Package mem_arb_pkg: state encoding, owner encoding (OWN_M0, OWN_M1), default MAX_WAIT/TIMEOUT constants.
- One sub-module, arb_picker: combinational winner select from (m0_req, m1_req, starve) → one-hot grant.
- The FSM, counters and bus mux stay in mem_bus_arbiter.

## Test plan
- CPU read alone: m0_req=1, we=0, addr=0x100; mem_ready one cycle later with mem_rdata=0xCAFEF00D → m0_ready pulses once with m0_rdata=0xCAFEF00D, m0_err=0; grant=01 during BUSY.
- Both masters request continuously, MAX_WAIT=8: master 0 wins until wait_cnt hits 8 → next IDLE grants master 1, and wait_cnt clears.
- Master 1 write alone, addr=0x2000, wdata=0x12345678: mem_we=1 only in BUSY; mem_addr/wdata match; m1_ready pulses, m1_rdata=0.
- Timeout, TIMEOUT=4, mem_ready held 0: DONE after 4 BUSY cycles with m0_err=1, m0_rdata=0; state returns to IDLE.
- Reset low during BUSY: all outputs go to 0 immediately and state=IDLE with no ready pulse; after reset release, a re-request completes normally.
- mem_ready and timeout coincide, TIMEOUT=3, mem_ready on the 3rd BUSY cycle: err=0 and data is latched.
